// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin arbiter granting one requester at a time bursty
//            access to a FIFO write port. Optional macro ARB_LOCK_EN adds a
//            per-requester lock input that suppresses the burst-length release.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   data,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]      lock,
`endif
  input  logic                 write_rdy,
  output logic [NREQ-1:0]      gnt,
  output logic                 write_en,
  output logic [DW-1:0]        write_data,
  output logic                 busy
);

  localparam int         IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] C_MAX = 4'(MAX_BURST);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [3:0]      r_cnt;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_owner;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic            w_req_own;
  logic            w_accept;
  logic            w_lock;
  logic [3:0]      w_cnt_nxt;
  logic            w_burst_end;

  // Round-robin search starting just above the previous winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_found && req[(int'(r_last) + i) % NREQ]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_last) + i) % NREQ);
      end
    end
  end

`ifdef ARB_LOCK_EN
  assign w_lock = lock[r_owner];
`else
  assign w_lock = 1'b0;
`endif

  assign w_req_own   = req[r_owner];
  assign w_accept    = (r_state == S_GRANT) && w_req_own && write_rdy;
  assign w_cnt_nxt   = r_cnt + 4'd1;
  // >= so that a burst stretched by lock still ends once lock drops.
  assign w_burst_end = w_accept && (w_cnt_nxt >= C_MAX) && !w_lock;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_cnt   <= 4'd0;
      r_last  <= IW'(NREQ - 1);
      r_owner <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_gnt   <= NREQ'(1) << w_win;
            r_owner <= w_win;
            r_cnt   <= 4'd0;
          end
        end
        S_GRANT: begin
          if (!w_req_own || w_burst_end) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_last  <= r_owner;
          end else if (w_accept && (r_cnt != 4'hF)) begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign busy       = (r_state == S_GRANT);
  assign write_en   = w_accept;
  assign write_data = busy ? data[int'(r_owner)*DW +: DW] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// Directed bench for fifo_wr_arbiter: grant/busy/write_en checked per cycle,
// written data checked against a queue of expected beats.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]   lock;
  logic              write_rdy;
  logic [NREQ-1:0]   gnt;
  logic              write_en;
  logic [DW-1:0]     write_data;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;
  int stepno   = 0;
  logic [DW-1:0] exp_q[$];

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req        (req),
    .data       (data),
`ifdef ARB_LOCK_EN
    .lock       (lock),
`endif
    .write_rdy  (write_rdy),
    .gnt        (gnt),
    .write_en   (write_en),
    .write_data (write_data),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp, stepno);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check registered/comb outputs,
  // and queue the beat the FIFO should receive in this cycle.
  task automatic step(input logic rst, input logic [NREQ-1:0] r, input logic rdy,
                      input logic [NREQ-1:0] egnt, input logic ewe);
    int owner;
    @(negedge CLK);
    RST       = rst;
    req       = r;
    write_rdy = rdy;
    stepno++;
    for (int i = 0; i < NREQ; i++) data[i*DW +: DW] = {i[2:0], stepno[4:0]};
    #1;
    check("gnt", 32'(gnt), 32'(egnt));
    check("busy", 32'(busy), 32'(|egnt));
    check("write_en", 32'(write_en), 32'(ewe));
    if (egnt == '0) check("write_data_idle", 32'(write_data), 32'd0);
    if (ewe) begin
      owner = 0;
      for (int i = 0; i < NREQ; i++) if (egnt[i]) owner = i;
      exp_q.push_back({owner[2:0], stepno[4:0]});
    end
  endtask

  // Scoreboard side: every accepted beat must match the next queued beat.
  always begin
    logic [DW-1:0] e;
    @(negedge CLK);
    #2;
    if (write_en === 1'b1) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      check("write_data", 32'(write_data), 32'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; req = '0; write_rdy = 1'b1; data = '0; lock = '0;
    repeat (2) @(negedge CLK);
    step(1, 4'b0000, 1, 4'b0000, 0);
    step(0, 4'b0000, 1, 4'b0000, 0);

    // Single requester: 4-beat burst, one idle cycle, re-grant.
    step(0, 4'b0001, 1, 4'b0000, 0);
    repeat (4) step(0, 4'b0001, 1, 4'b0001, 1);
    step(0, 4'b0001, 1, 4'b0000, 0);
    repeat (4) step(0, 4'b0001, 1, 4'b0001, 1);
    step(0, 4'b0000, 1, 4'b0000, 0);
    step(0, 4'b0000, 1, 4'b0000, 0);

    // All requesting after reset: order 0,1,2,3,0.
    step(1, 4'b0000, 1, 4'b0000, 0);
    step(0, 4'b1111, 1, 4'b0000, 0);
    for (int j = 0; j < 5; j++) begin
      repeat (4) step(0, 4'b1111, 1, 4'(1 << (j % 4)), 1);
      if (j < 4) step(0, 4'b1111, 1, 4'b0000, 0);
      else       step(0, 4'b0000, 1, 4'b0000, 0);
    end

    // Owner 2 stalled by write_rdy low for 5 cycles mid-burst.
    step(0, 4'b0100, 1, 4'b0000, 0);
    repeat (2) step(0, 4'b0100, 1, 4'b0100, 1);
    repeat (5) step(0, 4'b0100, 0, 4'b0100, 0);
    repeat (2) step(0, 4'b0100, 1, 4'b0100, 1);
    step(0, 4'b0000, 1, 4'b0000, 0);

    // Owner 1 drops req after 2 beats; requester 3 waits, then wins.
    step(0, 4'b0010, 1, 4'b0000, 0);
    step(0, 4'b1010, 1, 4'b0010, 1);
    step(0, 4'b1010, 1, 4'b0010, 1);
    step(0, 4'b1000, 1, 4'b0010, 0);
    step(0, 4'b1000, 1, 4'b0000, 0);
    step(0, 4'b1000, 1, 4'b1000, 1);
    step(0, 4'b0000, 1, 4'b1000, 0);
    step(0, 4'b0000, 1, 4'b0000, 0);

    // Reset during beat 2 of requester 0; requester 0 first afterwards.
    step(0, 4'b0001, 1, 4'b0000, 0);
    step(0, 4'b0001, 1, 4'b0001, 1);
    step(1, 4'b0001, 1, 4'b0001, 1);
    step(0, 4'b1111, 1, 4'b0000, 0);
    repeat (4) step(0, 4'b1111, 1, 4'b0001, 1);
    step(0, 4'b0000, 1, 4'b0000, 0);

`ifdef ARB_LOCK_EN
    // Lock held by owner 0: 9 consecutive beats without burst release.
    lock = 4'b0001;
    step(0, 4'b0001, 1, 4'b0000, 0);
    repeat (9) step(0, 4'b0001, 1, 4'b0001, 1);
    step(0, 4'b0000, 1, 4'b0001, 0);
    step(0, 4'b0000, 1, 4'b0000, 0);
    lock = '0;
`endif

    @(negedge CLK);
    #3;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
